// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: state encoding, sync byte, bytes-per-word helper.
// The CHECK/ERR states are only reachable when LOADER_CKSUM_EN is defined.
package loader_pkg;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int bpw(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Byte stream from the UART and write port into instruction RAM.
// master = loader side, slave = UART/RAM side.
interface loader_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8
);
  logic [7:0]        uart_data;
  logic              uart_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    input  uart_data, uart_ready,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output uart_data, uart_ready,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_loader_rise_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of a level input.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic in_q;

  always_ff @(posedge clk) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign pulse = in & ~in_q;
endmodule

// File: rtl/uart_loader.sv
// Boot loader: turns the UART byte stream (A5, N, N big-endian words [, checksum]) into RAM writes,
// holding the CPU in reset until the image is complete. Optional checksum byte: LOADER_CKSUM_EN.
module uart_loader #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     reload,
  loader_if.master bus,
  output logic     cpu_hold,
  output logic     done,
  output logic     error
);
  import loader_pkg::*;

  localparam int BPW = bpw(WORD_W);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  state_t            state;
  logic              stb;
  logic [7:0]        n;
  logic [7:0]        cnt;
  logic [BCW-1:0]    bcnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] word_next;
  logic              last_byte;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .in    (bus.uart_ready),
    .pulse (stb)
  );

  if (BPW > 1) begin : g_multi
    assign word_next = {shreg[WORD_W-9:0], bus.uart_data};
  end else begin : g_single
    assign word_next = bus.uart_data;
  end

  assign last_byte = (bcnt == BCW'(BPW - 1));

`ifdef LOADER_CKSUM_EN
  logic [7:0] sum;
  logic       error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || reload) begin
      state        <= SYNC;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      n            <= '0;
      cnt          <= '0;
      bcnt         <= '0;
      shreg        <= '0;
`ifdef LOADER_CKSUM_EN
      sum          <= '0;
      error_q      <= 1'b0;
`endif
      // reload preserves the last written word on the bus
      if (reset) bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (bus.mem_we) bus.mem_addr <= bus.mem_addr + 1'b1;

      case (state)
        SYNC: if (stb && bus.uart_data == SYNC_BYTE) state <= LEN;

        LEN: if (stb) begin
          n    <= bus.uart_data;
          cnt  <= '0;
          bcnt <= '0;
`ifdef LOADER_CKSUM_EN
          sum  <= '0;
`endif
          if (bus.uart_data != 8'd0) begin
            state <= DATA;
          end else begin
`ifdef LOADER_CKSUM_EN
            state <= CHECK;
`else
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end
        end

        DATA: if (stb) begin
          shreg <= word_next;
`ifdef LOADER_CKSUM_EN
          sum   <= sum + bus.uart_data;
`endif
          if (last_byte) begin
            bcnt          <= '0;
            bus.mem_wdata <= word_next;
            bus.mem_we    <= 1'b1;
            cnt           <= cnt + 8'd1;
            if (cnt + 8'd1 == n) begin
`ifdef LOADER_CKSUM_EN
              state <= CHECK;
`else
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end

`ifdef LOADER_CKSUM_EN
        CHECK: if (stb) begin
          if (bus.uart_data == sum) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state   <= ERR;
            error_q <= 1'b1;
          end
        end

        ERR: cpu_hold <= 1'b1;
`endif

        DONE: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end

        default: state <= SYNC;
      endcase
    end
  end
endmodule
